// File: rtl/hazard_controller.sv
`default_nettype none
// hazard_controller: forwarding selects, load-use stall, branch flush and a data-memory wait
// sequencer for the 5-stage RV32 pipeline, plus saturating perf counters and a sticky timeout flag.
module hazard_controller #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic [1:0]       PCSrcE,
  input  logic             MemAccessM,
  input  logic             mem_ready,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             mem_busy,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [0:0] {
    S_RUN      = 1'b0,
    S_MEM_WAIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic       lw_stall, taken, mem_hold;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;
  logic [1:0] fwd_a, fwd_b;

  // M-stage result is newer than W-stage, so it takes priority.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wr_m,
                                         input logic [4:0] rd_m, input logic wr_w,
                                         input logic [4:0] rd_w);
    logic [1:0] sel;
    sel = 2'b00;
    if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = 2'b10;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    taken    = |PCSrcE;
    mem_hold = (state_q == S_MEM_WAIT) || (MemAccessM && !mem_ready);
    fwd_a    = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    fwd_b    = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);

    stall_f = lw_stall;
    stall_d = lw_stall;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = taken;
    flush_e = lw_stall || taken;
    flush_w = 1'b0;

    // Freeze the whole pipe while memory is outstanding; a taken branch in E resolves after exit.
    if (mem_hold) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_w = 1'b1;
    end

    if (!rst) begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_w = 1'b0;
      fwd_a   = 2'b00;
      fwd_b   = 2'b00;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    mem_err_d   = mem_err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    case (state_q)
      S_RUN: begin
        if (MemAccessM && !mem_ready) begin
          state_d = S_MEM_WAIT;
          wait_d  = '0;
        end
      end
      S_MEM_WAIT: begin
        if (wait_q != TIMEOUT_V) begin
          wait_d = wait_q + WAIT_W'(1);
        end
        if (wait_d == TIMEOUT_V) begin
          mem_err_d = 1'b1;
        end
        if (mem_ready) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase

    if (stall_f && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_d && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_RUN;
      wait_q      <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallF    = stall_f;
  assign StallD    = stall_d;
  assign StallE    = stall_e;
  assign StallM    = stall_m;
  assign FlushD    = flush_d;
  assign FlushE    = flush_e;
  assign FlushW    = flush_w;
  assign ForwardAE = fwd_a;
  assign ForwardBE = fwd_b;
  assign mem_busy  = rst && (state_q == S_MEM_WAIT);
  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// tb_hazard_controller: scoreboard bench; a behavioural model queues expected outputs per cycle.
module tb_hazard_controller;

  localparam int CNT_W   = 5;
  localparam int TIMEOUT = 4;
  localparam int SAT     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             RegWriteM, RegWriteW, MemAccessM, mem_ready;
  logic [1:0]       ResultSrcE, PCSrcE;
  logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             mem_busy, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .MemAccessM(MemAccessM), .mem_ready(mem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_busy(mem_busy), .mem_err(mem_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] stall;   // F D E M
    logic [2:0] flush;   // D E W
    logic [1:0] fa;
    logic [1:0] fb;
    logic       busy;
    logic       err;
    logic [7:0] sc;
    logic [7:0] fc;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  string phase = "init";

  // model state
  bit m_busy, m_err;
  int m_wait, m_sc, m_fc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] mdl_fwd(input logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t mdl_outputs();
    exp_t e;
    logic lw, tk;
    lw = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    tk = PCSrcE != 2'b00;
    e.fa = mdl_fwd(Rs1E);
    e.fb = mdl_fwd(Rs2E);
    if (m_busy || (MemAccessM && !mem_ready)) begin
      e.stall = 4'b1111;
      e.flush = 3'b001;
    end else begin
      e.stall = {lw, lw, 2'b00};
      e.flush = {tk, lw | tk, 1'b0};
    end
    e.busy = m_busy;
    e.err  = m_err;
    e.sc   = 8'(m_sc);
    e.fc   = 8'(m_fc);
    return e;
  endfunction

  task automatic mdl_reset();
    m_busy = 0; m_err = 0; m_wait = 0; m_sc = 0; m_fc = 0;
  endtask

  // One clock: queue the expectation, compare the DUT, advance the model across the edge.
  task automatic tick();
    exp_t e, got;
    e = mdl_outputs();
    exp_q.push_back(e);
    #1;
    got = exp_q.pop_front();
    check_eq({phase, "/stall"}, {28'd0, StallF, StallD, StallE, StallM}, {28'd0, got.stall});
    check_eq({phase, "/flush"}, {29'd0, FlushD, FlushE, FlushW}, {29'd0, got.flush});
    check_eq({phase, "/fwdA"}, {30'd0, ForwardAE}, {30'd0, got.fa});
    check_eq({phase, "/fwdB"}, {30'd0, ForwardBE}, {30'd0, got.fb});
    check_eq({phase, "/busy"}, {31'd0, mem_busy}, {31'd0, got.busy});
    check_eq({phase, "/err"}, {31'd0, mem_err}, {31'd0, got.err});
    check_eq({phase, "/stall_cnt"}, 32'(stall_cnt), 32'(got.sc));
    check_eq({phase, "/flush_cnt"}, 32'(flush_cnt), 32'(got.fc));
    @(posedge clk);
    if (e.stall[3] && m_sc < SAT) m_sc++;
    if (e.flush[2] && m_fc < SAT) m_fc++;
    if (!m_busy) begin
      if (MemAccessM && !mem_ready) begin
        m_busy = 1;
        m_wait = 0;
      end
    end else begin
      if (m_wait < TIMEOUT) m_wait++;
      if (m_wait >= TIMEOUT) m_err = 1;
      if (mem_ready) m_busy = 0;
    end
    #1;
  endtask

  task automatic set_idle();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
    MemAccessM = 0; mem_ready = 1;
  endtask

  initial begin
    rst = 1'b0;
    set_idle();
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset/stallF", {31'd0, StallF}, 32'd0);
    check_eq("reset/busy", {31'd0, mem_busy}, 32'd0);
    check_eq("reset/stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // forwarding: M beats W; x0 never forwards
    phase = "fwd";
    RegWriteM = 1; RdM = 5; RegWriteW = 1; RdW = 5; Rs1E = 5; Rs2E = 5;
    #1;
    check_eq("fwd/MbeatsW", {30'd0, ForwardAE}, 32'd2);
    tick();
    RdW = 9; Rs2E = 9;
    tick();
    RdM = 0; Rs1E = 0; RdW = 0;
    tick();
    set_idle();

    // load-use
    phase = "lwstall";
    ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
    #1;
    check_eq("lw/stallF", {31'd0, StallF}, 32'd1);
    tick();
    RdE = 0; Rs2D = 0;
    tick();
    set_idle();
    #1;
    check_eq("lw/stall_cnt", 32'(stall_cnt), 32'd1);

    // taken branch / jump
    phase = "branch";
    PCSrcE = 2'b01; tick();
    PCSrcE = 2'b10; tick();
    set_idle();
    #1;
    check_eq("br/flush_cnt", 32'(flush_cnt), 32'd2);

    // memory wait: ready low 3 cycles then high
    phase = "memwait";
    MemAccessM = 1; mem_ready = 0; PCSrcE = 2'b01;
    repeat (3) tick();
    mem_ready = 1;
    tick();
    set_idle();
    tick();
    check_eq("mw/stall_cnt", 32'(stall_cnt), 32'd5);
    check_eq("mw/no_err", {31'd0, mem_err}, 32'd0);

    // timeout: ready low 6 cycles
    phase = "timeout";
    MemAccessM = 1; mem_ready = 0;
    repeat (6) tick();
    mem_ready = 1;
    tick();
    set_idle();
    repeat (3) tick();
    check_eq("to/err_sticky", {31'd0, mem_err}, 32'd1);

    // async reset in the middle of a wait
    phase = "rstwait";
    MemAccessM = 1; mem_ready = 0;
    repeat (2) tick();
    #2 rst = 1'b0;
    #1;
    check_eq("rw/stallF", {31'd0, StallF}, 32'd0);
    check_eq("rw/stallM", {31'd0, StallM}, 32'd0);
    check_eq("rw/flushW", {31'd0, FlushW}, 32'd0);
    check_eq("rw/busy", {31'd0, mem_busy}, 32'd0);
    check_eq("rw/err", {31'd0, mem_err}, 32'd0);
    check_eq("rw/stall_cnt", 32'(stall_cnt), 32'd0);
    check_eq("rw/flush_cnt", 32'(flush_cnt), 32'd0);
    mdl_reset();
    set_idle();
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // random traffic
    phase = "random";
    for (int i = 0; i < 300; i++) begin
      Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
      Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
      RdE  = 5'($urandom_range(0, 7)); RdM  = 5'($urandom_range(0, 7));
      RdW  = 5'($urandom_range(0, 7));
      RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      ResultSrcE = 2'($urandom);
      PCSrcE = (ResultSrcE == 2'b01) ? 2'b00 : 2'($urandom_range(0, 3) == 0 ? 1 : 0);
      MemAccessM = 1'($urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    set_idle();
    tick();

    // saturation of both counters
    phase = "saturate";
    ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
    repeat (40) tick();
    set_idle();
    PCSrcE = 2'b01;
    repeat (40) tick();
    set_idle();
    tick();
    check_eq("sat/stall_cnt", 32'(stall_cnt), 32'(SAT));
    check_eq("sat/flush_cnt", 32'(flush_cnt), 32'(SAT));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
